// File: rtl/flit_track_multi.sv
// Multi-channel flit framing tracker: snoops valid/ready handshakes, decodes head-flit
// lengths and tracks head/body/tail position, packet completion and oversize errors per channel.

module flit_track_chan #(
  parameter int LEN_WIDTH = 8,
  parameter int MAX_LEN   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic                 i_ready,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic                 i_abort,
  input  logic                 i_err_clear,
  output logic                 o_is_head,
  output logic                 o_is_tail,
  output logic [LEN_WIDTH-1:0] o_remaining,
  output logic                 o_pkt_done,
  output logic                 o_len_error
);

  localparam logic [0:0] ST_HEAD = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  // One extra bit keeps the oversize compare meaningful when MAX_LEN is the field maximum.
  localparam logic [LEN_WIDTH:0]   MAX_LEN_W = (LEN_WIDTH+1)'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]           r_state;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic                 r_pkt_done;
  logic                 r_len_error;

  logic [0:0]           w_state_nxt;
  logic [LEN_WIDTH-1:0] w_remaining_nxt;
  logic                 w_pkt_done_nxt;
  logic                 w_len_error_nxt;
  logic                 w_xfer;
  logic                 w_oversize;
  logic                 w_len_zero;
  logic                 w_is_head;
  logic                 w_is_tail;

  assign w_xfer     = i_valid & i_ready;
  assign w_oversize = ({1'b0, i_len} > MAX_LEN_W);
  assign w_len_zero = (i_len == LEN_ZERO);

  // Flit classification from current state and head-flit length
  always_comb begin
    w_is_head = 1'b0;
    w_is_tail = 1'b0;
    case (r_state)
      ST_HEAD: begin
        w_is_head = 1'b1;
        w_is_tail = w_len_zero | w_oversize;
      end
      ST_BODY: begin
        w_is_head = 1'b0;
        w_is_tail = (r_remaining == LEN_ONE);
      end
      default: begin
        w_is_head = 1'b1;
        w_is_tail = w_len_zero | w_oversize;
      end
    endcase
  end

  // Next-state, counter, done and error logic
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_pkt_done_nxt  = 1'b0;
    w_len_error_nxt = r_len_error & ~i_err_clear;
    if (i_abort) begin
      w_state_nxt     = ST_HEAD;
      w_remaining_nxt = LEN_ZERO;
      w_pkt_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_HEAD: begin
          if (w_xfer) begin
            if (w_oversize) begin
              w_len_error_nxt = 1'b1;
              w_pkt_done_nxt  = 1'b1;
            end else if (w_len_zero) begin
              w_pkt_done_nxt  = 1'b1;
            end else begin
              w_state_nxt     = ST_BODY;
              w_remaining_nxt = i_len;
            end
          end else begin
            w_state_nxt = ST_HEAD;
          end
        end
        ST_BODY: begin
          if (w_xfer) begin
            // A zero count in BODY is unreachable; treating it like the tail avoids a wrap.
            if (r_remaining <= LEN_ONE) begin
              w_state_nxt     = ST_HEAD;
              w_remaining_nxt = LEN_ZERO;
              w_pkt_done_nxt  = 1'b1;
            end else begin
              w_remaining_nxt = r_remaining - LEN_ONE;
            end
          end else begin
            w_state_nxt = ST_BODY;
          end
        end
        default: begin
          w_state_nxt     = ST_HEAD;
          w_remaining_nxt = LEN_ZERO;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_HEAD;
      r_remaining <= LEN_ZERO;
      r_pkt_done  <= 1'b0;
      r_len_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_pkt_done  <= w_pkt_done_nxt;
      r_len_error <= w_len_error_nxt;
    end
  end

  assign o_is_head   = w_is_head;
  assign o_is_tail   = w_is_tail;
  assign o_remaining = r_remaining;
  assign o_pkt_done  = r_pkt_done;
  assign o_len_error = r_len_error;

endmodule

module flit_track_multi #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int LEN_LSB    = 0,
  parameter int MAX_LEN    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            flit_valid,
  input  logic [NUM_CH-1:0]            flit_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] flit_data,
  input  logic [NUM_CH-1:0]            abort,
  input  logic                         err_clear,
  output logic [NUM_CH-1:0]            is_head,
  output logic [NUM_CH-1:0]            is_tail,
  output logic [NUM_CH*LEN_WIDTH-1:0]  remaining,
  output logic [NUM_CH-1:0]            pkt_done,
  output logic [NUM_CH-1:0]            len_error
);

  // Payload bits outside the length field are deliberately ignored.
  logic w_unused_data;
  assign w_unused_data = ^flit_data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [LEN_WIDTH-1:0] w_len;
    assign w_len = flit_data[g*DATA_WIDTH+LEN_LSB +: LEN_WIDTH];

    flit_track_chan #(
      .LEN_WIDTH (LEN_WIDTH),
      .MAX_LEN   (MAX_LEN)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .i_valid     (flit_valid[g]),
      .i_ready     (flit_ready[g]),
      .i_len       (w_len),
      .i_abort     (abort[g]),
      .i_err_clear (err_clear),
      .o_is_head   (is_head[g]),
      .o_is_tail   (is_tail[g]),
      .o_remaining (remaining[g*LEN_WIDTH +: LEN_WIDTH]),
      .o_pkt_done  (pkt_done[g]),
      .o_len_error (len_error[g])
    );
  end

endmodule

// File: tb/tb_flit_track_multi.sv
// Directed bench for flit_track_multi (MAX_LEN=16): hand-computed expectations per step.

module tb_flit_track_multi;

  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int LW     = 8;

  logic                 clk;
  logic                 reset;
  logic [NUM_CH-1:0]    flit_valid;
  logic [NUM_CH-1:0]    flit_ready;
  logic [NUM_CH*DW-1:0] flit_data;
  logic [NUM_CH-1:0]    abort;
  logic                 err_clear;
  logic [NUM_CH-1:0]    is_head;
  logic [NUM_CH-1:0]    is_tail;
  logic [NUM_CH*LW-1:0] remaining;
  logic [NUM_CH-1:0]    pkt_done;
  logic [NUM_CH-1:0]    len_error;

  int n_total;
  int n_bad;

  flit_track_multi #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .LEN_LSB(0), .MAX_LEN(16)
  ) dut (
    .clk(clk), .reset(reset), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .flit_data(flit_data), .abort(abort), .err_clear(err_clear),
    .is_head(is_head), .is_tail(is_tail), .remaining(remaining),
    .pkt_done(pkt_done), .len_error(len_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_flit(input int c, input logic [31:0] d);
    flit_data[c*DW +: DW] = d;
  endtask

  function automatic logic [31:0] rem(input int c);
    return 32'(remaining[c*LW +: LW]);
  endfunction

  initial begin
    logic [4:0] rdy_seq;
    logic [7:0] rem_seq [5];
    n_total    = 0;
    n_bad      = 0;
    reset      = 1'b0;
    flit_valid = 4'b0000;
    flit_ready = 4'b0000;
    flit_data  = '0;
    abort      = 4'b0000;
    err_clear  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // reset / idle
    check("rst_head", 32'(is_head), 32'h0000_000f);
    check("rst_tail", 32'(is_tail), 32'h0000_000f);
    check("rst_rem", remaining, 32'h0000_0000);
    check("rst_done", 32'(pkt_done), 32'h0000_0000);
    check("rst_err", 32'(len_error), 32'h0000_0000);

    // ch0: head L=3 then three body flits
    flit_valid[0] = 1'b1;
    flit_ready[0] = 1'b1;
    set_flit(0, 32'h1234_5603);
    settle();
    check("c0_head_tail", 32'(is_tail[0]), 32'd0);
    tick();
    check("c0_rem3", rem(0), 32'd3);
    check("c0_nohead", 32'(is_head[0]), 32'd0);
    check("c0_done_head", 32'(pkt_done[0]), 32'd0);
    set_flit(0, 32'hdead_be00);
    settle();
    check("c0_b1_tail", 32'(is_tail[0]), 32'd0);
    tick();
    check("c0_rem2", rem(0), 32'd2);
    check("c0_b2_tail", 32'(is_tail[0]), 32'd0);
    tick();
    check("c0_rem1", rem(0), 32'd1);
    check("c0_b3_tail", 32'(is_tail[0]), 32'd1);
    tick();
    check("c0_rem0", rem(0), 32'd0);
    check("c0_done", 32'(pkt_done[0]), 32'd1);
    check("c0_head_again", 32'(is_head[0]), 32'd1);
    flit_valid[0] = 1'b0;
    tick();
    check("c0_done_once", 32'(pkt_done[0]), 32'd0);

    // ch1: head L=2, ready toggling 1,0,1,0,1
    rdy_seq    = 5'b10101;
    rem_seq[0] = 8'd2; rem_seq[1] = 8'd2; rem_seq[2] = 8'd1; rem_seq[3] = 8'd1; rem_seq[4] = 8'd0;
    flit_valid[1] = 1'b1;
    set_flit(1, 32'h0000_0002);
    for (int i = 0; i < 5; i++) begin
      flit_ready[1] = rdy_seq[i];
      tick();
      check($sformatf("c1_rem_%0d", i), rem(1), 32'(rem_seq[i]));
      check($sformatf("c1_done_%0d", i), 32'(pkt_done[1]), (i == 4) ? 32'd1 : 32'd0);
    end
    check("c1_head_end", 32'(is_head[1]), 32'd1);
    flit_valid[1] = 1'b0;
    flit_ready[1] = 1'b0;

    // ch2: three back-to-back single-flit packets
    flit_valid[2] = 1'b1;
    flit_ready[2] = 1'b1;
    set_flit(2, 32'hffff_ff00);
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("c2_tail_%0d", i), 32'(is_tail[2]), 32'd1);
      tick();
      check($sformatf("c2_done_%0d", i), 32'(pkt_done[2]), 32'd1);
      check($sformatf("c2_head_%0d", i), 32'(is_head[2]), 32'd1);
      check($sformatf("c2_rem_%0d", i), rem(2), 32'd0);
    end
    flit_valid[2] = 1'b0;
    tick();
    check("c2_done_off", 32'(pkt_done[2]), 32'd0);

    // ch3: oversize length, err_clear vs new error, then clear
    flit_valid[3] = 1'b1;
    flit_ready[3] = 1'b1;
    set_flit(3, 32'h0000_00c8);
    settle();
    check("c3_ovr_tail", 32'(is_tail[3]), 32'd1);
    tick();
    check("c3_err", 32'(len_error), 32'h0000_0008);
    check("c3_ovr_done", 32'(pkt_done[3]), 32'd1);
    check("c3_ovr_head", 32'(is_head[3]), 32'd1);
    check("c3_ovr_rem", rem(3), 32'd0);
    set_flit(3, 32'h0000_0011);
    err_clear = 1'b1;
    tick();
    check("c3_err_wins", 32'(len_error[3]), 32'd1);
    flit_valid[3] = 1'b0;
    tick();
    check("c3_err_clr", 32'(len_error[3]), 32'd0);
    err_clear = 1'b0;
    // L == MAX_LEN is legal
    flit_valid[3] = 1'b1;
    set_flit(3, 32'h0000_0010);
    settle();
    check("c3_max_tail", 32'(is_tail[3]), 32'd0);
    tick();
    check("c3_max_rem", rem(3), 32'd16);
    check("c3_max_err", 32'(len_error[3]), 32'd0);
    flit_valid[3] = 1'b0;
    abort[3] = 1'b1;
    tick();
    abort[3] = 1'b0;
    check("c3_abort_rem", rem(3), 32'd0);
    check("c3_abort_head", 32'(is_head[3]), 32'd1);

    // ch0 abort mid-packet with simultaneous transfer
    flit_valid[0] = 1'b1;
    flit_ready[0] = 1'b1;
    set_flit(0, 32'h0000_0005);
    tick();
    check("c0_ab_rem5", rem(0), 32'd5);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("c0_ab_rem", rem(0), 32'd0);
    check("c0_ab_head", 32'(is_head[0]), 32'd1);
    check("c0_ab_done", 32'(pkt_done[0]), 32'd0);

    // reset mid-packet on ch0 and ch1
    flit_valid[1] = 1'b1;
    flit_ready[1] = 1'b1;
    set_flit(1, 32'h0000_0004);
    tick();
    check("rs_rem", remaining, 32'h0000_0405);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    flit_valid = 4'b0000;
    flit_ready = 4'b0000;
    check("rs_rem0", remaining, 32'h0000_0000);
    check("rs_head", 32'(is_head), 32'h0000_000f);
    check("rs_done", 32'(pkt_done), 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
